// File: rtl/simplez_tx_port.sv
// simplez_tx_port: FIFO-buffered UART transmitter on the Simplez CPU store path (8N1 frames).
// Define SIMPLEZ_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1 frames).
module simplez_tx_port #(
  parameter int BAUD_DIV   = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr,
  input  logic [11:0] din,
  input  logic        clr,
  output logic        tx,
  output logic        ready,
  output logic        busy,
  output logic        ovf,
  output logic [11:0] status
);
  localparam int DATA_W = 8;
  localparam int CW     = $clog2(BAUD_DIV);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef SIMPLEZ_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [AW:0]         count;
  logic                tick, fifo_empty, fifo_full, push, pop, drop;
  logic                unused_din;

  assign unused_din = ^din[11:DATA_W];

  assign tick       = (cnt == CNT_LAST);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign push       = wr && !fifo_full;
  assign drop       = wr && fifo_full;
  assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && tick));

  assign ready  = !fifo_full;
  assign busy   = (state != S_IDLE) || !fifo_empty;
  assign status = {9'b0, ovf, busy, ready};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_START;
      S_START:  if (tick) state_nxt = S_DATA;
`ifdef SIMPLEZ_TX_PARITY_EN
      S_DATA:   if (tick && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (tick) state_nxt = S_STOP;
`else
      S_DATA:   if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      // Back-to-back frames: the next start bit follows the stop bit directly.
      S_STOP:   if (tick) state_nxt = fifo_empty ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef SIMPLEZ_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (pop) par_bit <= ^mem[rptr];
  end
`endif

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
`ifdef SIMPLEZ_TX_PARITY_EN
      S_PARITY: tx = par_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      // Every state change happens on a tick (or out of IDLE, where cnt is held at 0).
      cnt <= (state == S_IDLE || tick) ? '0 : cnt + CW'(1);
      if (state == S_DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (drop)     ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din[DATA_W-1:0];
    if (pop)                       shreg <= mem[rptr];
    else if (state == S_DATA && tick) shreg <= shreg >> 1;
  end

endmodule

// File: tb/tb_simplez_tx_port.sv
// Bench for simplez_tx_port: directed steps plus random writes, checked against an
// ideal frame schedule model and a mid-bit sampling UART receiver.
module tb_simplez_tx_port;
  localparam int B     = 4;
  localparam int DEPTH = 4;
`ifdef SIMPLEZ_TX_PARITY_EN
  localparam int FRAME = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FB = FRAME * B;

  logic        clk = 1'b0, rstn = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [11:0] din = '0;
  logic        tx, ready, busy, ovf;
  logic [11:0] status;

  simplez_tx_port #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .wr(wr), .din(din), .clr(clr),
    .tx(tx), .ready(ready), .busy(busy), .ovf(ovf), .status(status)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int edge_n = 0;
  int fall_edge = -1, idle_edge = -1;
  int          st_q[$];   // model: edge at which each accepted byte's start bit appears
  logic [7:0]  by_q[$];   // model: accepted bytes in order
  logic        ovf_m = 1'b0;
  logic [7:0]  rx_q[$];
  logic        rx_pq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Byte written at edge t: accepted if fewer than DEPTH bytes still wait to start;
  // it starts one edge later or when the previous frame ends, whichever is later.
  function automatic bit model_write(input int t, input logic [7:0] b);
    int pend = 0;
    int s;
    foreach (st_q[i]) if (st_q[i] >= t) pend++;
    if (pend >= DEPTH) return 1'b1;
    s = t + 1;
    if (st_q.size() > 0 && st_q[st_q.size()-1] + FB > s) s = st_q[st_q.size()-1] + FB;
    st_q.push_back(s);
    by_q.push_back(b);
    return 1'b0;
  endfunction

  // Reset keeps only frames already complete at edge c.
  task automatic model_reset(input int c);
    int         ns[$];
    logic [7:0] nb[$];
    foreach (st_q[i]) if (st_q[i] + FB <= c) begin ns.push_back(st_q[i]); nb.push_back(by_q[i]); end
    st_q = ns;
    by_q = nb;
    ovf_m = 1'b0;
  endtask

  task automatic expect_at(input int c, output logic etx, output logic [11:0] est);
    int         pend = 0;
    int         slot;
    logic       inf = 1'b0;
    logic [7:0] bb;
    etx = 1'b1;
    foreach (st_q[i]) begin
      if (st_q[i] > c) pend++;
      else if (c < st_q[i] + FB) begin
        inf  = 1'b1;
        slot = (c - st_q[i]) / B;
        bb   = by_q[i];
        if (slot == 0)                etx = 1'b0;
        else if (slot <= 8)           etx = bb[slot-1];
        else if (PAR && slot == 9)    etx = ^bb;
        else                          etx = 1'b1;
      end
    end
    est = {9'b0, ovf_m, inf || (pend > 0), pend < DEPTH};
  endtask

  task automatic step(input logic w, input logic [11:0] d, input logic c);
    logic        etx;
    logic [11:0] est;
    bit          drop;
    wr = w; din = d; clr = c;
    @(posedge clk);
    edge_n++;
    drop = 1'b0;
    if (rstn) begin
      if (w) drop = model_write(edge_n, d[7:0]);
      if (drop)   ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
    end
    @(negedge clk);
    expect_at(edge_n, etx, est);
    check("tx", 32'(tx), 32'(etx));
    check("status", 32'(status), 32'(est));
    if (tx === 1'b0 && fall_edge < 0) fall_edge = edge_n;
    if (fall_edge >= 0 && idle_edge < 0 && busy === 1'b0) idle_edge = edge_n;
    wr = 1'b0; clr = 1'b0;
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic par_at(input int i);
    return (i < rx_pq.size()) ? rx_pq[i] : 1'bx;
  endfunction

  // Receiver: detects the start bit, samples each bit in its middle.
  int         rx_ph;
  bit         rx_on = 1'b0;
  logic [7:0] rx_sh;
  logic       rx_par = 1'b0;
  always @(negedge clk) begin
    if (!rstn) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin rx_on = 1'b1; rx_ph = 0; end
    end else begin
      rx_ph++;
      if (rx_ph % B == B / 2) begin
        if (rx_ph / B >= 1 && rx_ph / B <= 8) rx_sh[rx_ph / B - 1] = tx;
        else if (PAR && rx_ph / B == 9) rx_par = tx;
        else if (rx_ph / B == FRAME - 1) begin
          rx_q.push_back(rx_sh);
          rx_pq.push_back(rx_par);
          rx_on = 1'b0;
        end
      end
    end
  end

  initial begin
    int         wk, base, n;
    logic [7:0] bytes [6];

    // Reset and idle
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rstn = 1'b1;
    repeat (50) step(1'b0, '0, 1'b0);
    check("idle_status", 32'(status), 32'h001);

    // Single byte
    fall_edge = -1; idle_edge = -1; base = rx_q.size();
    step(1'b1, 12'hF55, 1'b0);
    wk = edge_n;
    repeat (FB + 5) step(1'b0, '0, 1'b0);
    check("start_latency", fall_edge - wk, 1);
    check("busy_len", idle_edge - fall_edge, FB);
    check("single_rx", 32'(rx_at(base)), 32'h55);

    // Burst "ABC"
    fall_edge = -1; idle_edge = -1; base = rx_q.size();
    step(1'b1, 12'h041, 1'b0);
    step(1'b1, 12'h042, 1'b0);
    step(1'b1, 12'h043, 1'b0);
    repeat (3 * FB + 5) step(1'b0, '0, 1'b0);
    check("burst_len", idle_edge - fall_edge, 3 * FB);
    check("burst_cnt", rx_q.size() - base, 3);
    check("burst_A", 32'(rx_at(base)), 32'h41);
    check("burst_B", 32'(rx_at(base + 1)), 32'h42);
    check("burst_C", 32'(rx_at(base + 2)), 32'h43);

    // Overflow: six back-to-back writes, the sixth is dropped
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      bytes[i] = 8'($urandom);
      step(1'b1, {4'hA, bytes[i]}, 1'b0);
      if (i == 3) check("ready_after4", 32'(ready), 32'h1);
      if (i == 4) check("ready_after5", 32'(ready), 32'h0);
    end
    check("ovf_set", 32'(ovf), 32'h1);
    repeat (5 * FB + 5) step(1'b0, '0, 1'b0);
    check("ovf_rx_cnt", rx_q.size() - base, 5);
    for (int i = 0; i < 5; i++) check("ovf_rx_byte", 32'(rx_at(base + i)), 32'(bytes[i]));
    check("ovf_sticky", 32'(ovf), 32'h1);
    step(1'b0, '0, 1'b1);
    check("ovf_clr", 32'(ovf), 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 12'(i), i == 5);
    check("ovf_set_wins", 32'(ovf), 32'h1);
    repeat (5 * FB + 5) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);

    // Random bursts, gaps and clears
    repeat (40) begin
      n = $urandom_range(1, 6);
      repeat (n) step(1'b1, 12'($urandom), $urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 2 * FB)) step(1'b0, '0, $urandom_range(0, 5) == 0);
    end
    repeat (6 * FB) step(1'b0, '0, 1'b0);
    check("all_rx_cnt", rx_q.size(), by_q.size());
    foreach (by_q[i]) check("all_rx_byte", 32'(rx_at(i)), 32'(by_q[i]));

    // Reset during data bit 3 with two bytes queued
    base = rx_q.size();
    step(1'b1, 12'h000, 1'b0);
    wk = edge_n;
    step(1'b1, 12'h0FF, 1'b0);
    step(1'b1, 12'h0AA, 1'b0);
    while (edge_n < wk + 1 + 4 * B + 1) step(1'b0, '0, 1'b0);
    check("pre_rst_tx", 32'(tx), 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'h1);
    check("rst_async_status", 32'(status), 32'h001);
    model_reset(edge_n);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rstn = 1'b1;
    repeat (3 * FB) step(1'b0, '0, 1'b0);
    check("rst_no_frames", rx_q.size(), base);
    check("rst_busy", 32'(busy), 32'h0);

`ifdef SIMPLEZ_TX_PARITY_EN
    // Even parity
    fall_edge = -1; idle_edge = -1; base = rx_q.size();
    step(1'b1, 12'h007, 1'b0);
    repeat (FB + 5) step(1'b0, '0, 1'b0);
    check("par_len", idle_edge - fall_edge, 11 * B);
    check("par07_byte", 32'(rx_at(base)), 32'h07);
    check("par07_bit", 32'(par_at(base)), 32'h1);
    step(1'b1, 12'h003, 1'b0);
    repeat (FB + 5) step(1'b0, '0, 1'b0);
    check("par03_byte", 32'(rx_at(base + 1)), 32'h03);
    check("par03_bit", 32'(par_at(base + 1)), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
